// File: rtl/axis_tx_arbiter.sv
// Round-robin, frame-locked arbiter that shares one AXI-stream byte sink among NUM byte sources.
// Each grant optionally begins with a header byte 8'hF0|index before the payload is passed through.
module axis_tx_arbiter #(
    parameter int         NUM        = 4,
    parameter int         MAX_BURST  = 64,
    parameter logic [7:0] TERMINATOR = 8'h0A,
    parameter int         HEADER     = 1,
    parameter int         TIMEOUT    = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [8*NUM-1:0] idata,
    input  logic [NUM-1:0]   ivalid,
    output logic [NUM-1:0]   iready,
    output logic [7:0]       odata,
    output logic             ovalid,
    input  logic             oready,
    output logic [NUM-1:0]   grant
);

    localparam int XW = $clog2(NUM);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_PASS
    } state_t;

    state_t        state;
    logic [XW-1:0] last;        // doubles as the current owner index while a frame is open
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] idle_cnt;
    logic [XW-1:0] pick;
    logic [7:0]    src_byte [NUM];
    logic          owner_valid;
    logic          owner_xfer;
    logic          frame_end;

    for (genvar i = 0; i < NUM; i++) begin : g_split
        assign src_byte[i] = idata[8*i +: 8];
    end

    // First requester in cyclic order from+1 .. from+NUM.
    function automatic logic [XW-1:0] next_owner(input logic [NUM-1:0] req,
                                                 input logic [XW-1:0]  from);
        logic [XW-1:0] sel;
        logic          found;
        int            cand;
        sel   = from;
        found = 1'b0;
        for (int i = 1; i <= NUM; i++) begin
            cand = (int'(from) + i) % NUM;
            if (!found && req[XW'(cand)]) begin
                sel   = XW'(cand);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign pick        = next_owner(ivalid, last);
    assign owner_valid = ivalid[last];
    assign owner_xfer  = owner_valid && oready;
    assign frame_end   = (src_byte[last] == TERMINATOR) ||
                         (burst_cnt == BW'(MAX_BURST - 1));

    // Payload path is combinational so the sink sees the owner with zero latency.
    always_comb begin
        odata  = 8'h00;
        ovalid = 1'b0;
        iready = '0;
        case (state)
            S_HEADER: begin
                ovalid = 1'b1;
                odata  = 8'hF0 | 8'(last);
            end
            S_PASS: begin
                odata        = src_byte[last];
                ovalid       = owner_valid;
                iready[last] = oready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            grant     <= '0;
            last      <= XW'(NUM - 1);
            burst_cnt <= '0;
            idle_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|ivalid) begin
                        last      <= pick;
                        grant     <= {{(NUM-1){1'b0}}, 1'b1} << pick;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                        state     <= (HEADER != 0) ? S_HEADER : S_PASS;
                    end
                end
                S_HEADER: begin
                    if (oready) state <= S_PASS;
                end
                S_PASS: begin
                    if (owner_xfer) begin
                        idle_cnt <= '0;
                        if (frame_end) begin
                            state <= S_IDLE;
                            grant <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end else if (owner_valid) begin
                        idle_cnt <= '0;
                    end else if (TIMEOUT > 0) begin
                        // An idle owner has nothing pending, so releasing here drops no byte.
                        if (idle_cnt == TW'(TIMEOUT - 1)) begin
                            state <= S_IDLE;
                            grant <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_tx_arbiter.sv
// Bench for axis_tx_arbiter: per-source byte queues drive the DUT and a frame-level
// round-robin model predicts the exact byte/grant sequence seen at the sink.
module tb_axis_tx_arbiter;

    localparam int         NUM  = 4;
    localparam int         MAXB = 64;
    localparam int         TOUT = 16;
    localparam logic [7:0] TERM = 8'h0A;

    logic             clock = 1'b0;
    logic             reset;
    logic [8*NUM-1:0] idata;
    logic [NUM-1:0]   ivalid;
    logic [NUM-1:0]   iready;
    logic [7:0]       odata;
    logic             ovalid;
    logic             oready;
    logic [NUM-1:0]   grant;

    axis_tx_arbiter #(
        .NUM(NUM), .MAX_BURST(MAXB), .TERMINATOR(TERM), .HEADER(1), .TIMEOUT(TOUT)
    ) dut (
        .clock(clock), .reset(reset), .idata(idata), .ivalid(ivalid), .iready(iready),
        .odata(odata), .ovalid(ovalid), .oready(oready), .grant(grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]     b;
        logic [NUM-1:0] g;
        int             cyc;
    } ent_t;

    logic [7:0]     srcq [NUM][$];
    ent_t           out_log[$];
    ent_t           exp_log[$];
    logic [NUM-1:0] gtrace[$];
    int cyc, viol, pops, omode;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic cycle();
        ent_t       e;
        logic [7:0] tmp;
        for (int i = 0; i < NUM; i++) begin
            if (srcq[i].size() > 0) begin
                ivalid[i]      = 1'b1;
                idata[8*i +: 8] = srcq[i][0];
            end else begin
                ivalid[i]      = 1'b0;
                idata[8*i +: 8] = 8'($urandom);
            end
        end
        case (omode)
            0:       oready = 1'b1;
            1:       oready = (cyc % 2 == 0);
            default: oready = ($urandom_range(0, 3) != 0);
        endcase
        @(negedge clock);
        if (ovalid && oready) begin
            e.b = odata; e.g = grant; e.cyc = cyc;
            out_log.push_back(e);
        end
        if ((iready & ~grant) != '0 || (iready != '0 && !oready)) viol++;
        for (int i = 0; i < NUM; i++) begin
            if (ivalid[i] && iready[i]) begin
                tmp = srcq[i].pop_front();
                pops++;
            end
        end
        gtrace.push_back(grant);
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        ivalid = '0;
        idata  = '0;
        oready = 1'b0;
        omode  = 0;
        for (int i = 0; i < NUM; i++) srcq[i].delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0; viol = 0; pops = 0;
        out_log.delete();
        gtrace.delete();
    endtask

    // Frame-level reference: owners rotate among non-empty queues; a grant covers a header
    // then bytes until the terminator, MAX_BURST bytes, or the queue runs dry (timeout).
    task automatic build_model(input int start_last);
        logic [7:0] mq [NUM][$];
        logic [7:0] b;
        int   last, s, n;
        ent_t e;
        exp_log.delete();
        for (int i = 0; i < NUM; i++) mq[i] = srcq[i];
        last = start_last;
        while (1) begin
            s = -1;
            for (int k = 1; k <= NUM; k++)
                if (s < 0 && mq[(last + k) % NUM].size() > 0) s = (last + k) % NUM;
            if (s < 0) break;
            last  = s;
            e.g   = '0;
            e.g[s] = 1'b1;
            e.cyc = 0;
            e.b   = 8'hF0 | 8'(s);
            exp_log.push_back(e);
            n = 0;
            while (mq[s].size() > 0) begin
                b   = mq[s].pop_front();
                e.b = b;
                exp_log.push_back(e);
                n++;
                if (b == TERM || n == MAXB) break;
            end
        end
    endtask

    task automatic run(input int budget);
        int  n;
        bit  empty;
        n = 0;
        while (n < budget) begin
            empty = 1'b1;
            for (int i = 0; i < NUM; i++) if (srcq[i].size() > 0) empty = 1'b0;
            if (empty && out_log.size() >= exp_log.size()) break;
            cycle();
            n++;
        end
        n_checks++;
        if (n >= budget) $display("FAIL run_budget: ran %0d cycles, limit %0d", n, budget);
        else n_pass++;
        repeat (TOUT + 8) cycle();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        ivalid = '1;
        idata  = '1;
        oready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b0) $display("FAIL reset_ovalid: got %b want 0", ovalid); else n_pass++;
        n_checks++; if (iready !== '0) $display("FAIL reset_iready: got %b want 0000", iready); else n_pass++;
        n_checks++; if (grant !== '0) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
        n_checks++; if (odata !== 8'h00) $display("FAIL reset_odata: got %h want 00", odata); else n_pass++;
        apply_reset();
    endtask

    task automatic test_single_frame();
        apply_reset();
        srcq[0] = '{8'h41, 8'h42, 8'h0A};
        build_model(NUM - 1);
        run(200);
        n_checks++;
        if (out_log.size() != exp_log.size())
            $display("FAIL t1_count: got %0d bytes want %0d", out_log.size(), exp_log.size());
        else n_pass++;
        for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
            n_checks++;
            if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                $display("FAIL t1_byte[%0d]: got %h/%b want %h/%b", k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
            else n_pass++;
        end
        if (out_log.size() == 4) begin
            n_checks++; if (out_log[0].cyc != 1) $display("FAIL t1_hdr_cycle: got %0d want 1", out_log[0].cyc); else n_pass++;
            n_checks++; if (out_log[3].cyc != 4) $display("FAIL t1_term_cycle: got %0d want 4", out_log[3].cyc); else n_pass++;
            n_checks++; if (gtrace[5] !== '0) $display("FAIL t1_bubble: grant %b want 0000", gtrace[5]); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 1; i < NUM; i++) srcq[i] = '{8'h0A, 8'h0A, 8'h0A};
        build_model(NUM - 1);
        run(300);
        n_checks++;
        if (out_log.size() != exp_log.size())
            $display("FAIL t2_count: got %0d bytes want %0d", out_log.size(), exp_log.size());
        else n_pass++;
        for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
            n_checks++;
            if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                $display("FAIL t2_byte[%0d]: got %h/%b want %h/%b", k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
            else n_pass++;
        end
    endtask

    task automatic test_max_burst();
        apply_reset();
        for (int k = 0; k < 100; k++) srcq[0].push_back(8'(k + 16));
        srcq[2] = '{8'h77, 8'h0A};
        build_model(NUM - 1);
        run(3000);
        n_checks++;
        if (out_log.size() != exp_log.size())
            $display("FAIL t3_count: got %0d bytes want %0d", out_log.size(), exp_log.size());
        else n_pass++;
        for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
            n_checks++;
            if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                $display("FAIL t3_byte[%0d]: got %h/%b want %h/%b", k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
            else n_pass++;
        end
    endtask

    task automatic test_oready_toggle();
        apply_reset();
        omode   = 1;
        srcq[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h0A};
        srcq[1] = '{8'h0A};
        build_model(NUM - 1);
        run(300);
        n_checks++;
        if (out_log.size() != exp_log.size())
            $display("FAIL t4_count: got %0d bytes want %0d", out_log.size(), exp_log.size());
        else n_pass++;
        for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
            n_checks++;
            if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                $display("FAIL t4_byte[%0d]: got %h/%b want %h/%b", k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
            else n_pass++;
        end
        n_checks++; if (viol != 0) $display("FAIL t4_iready_rule: %0d bad cycles want 0", viol); else n_pass++;
        n_checks++; if (pops != 6) $display("FAIL t4_source_pops: got %0d want 6", pops); else n_pass++;
    endtask

    task automatic test_timeout();
        int t0, cnt;
        apply_reset();
        srcq[1] = '{8'h55};
        srcq[3] = '{8'h0A};
        build_model(NUM - 1);
        run(400);
        n_checks++;
        if (out_log.size() != exp_log.size())
            $display("FAIL t5_count: got %0d bytes want %0d", out_log.size(), exp_log.size());
        else n_pass++;
        for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
            n_checks++;
            if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                $display("FAIL t5_byte[%0d]: got %h/%b want %h/%b", k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
            else n_pass++;
        end
        if (out_log.size() == 4 && gtrace.size() > out_log[1].cyc + 18) begin
            t0  = out_log[1].cyc;
            cnt = 0;
            for (int k = t0 + 1; k < gtrace.size(); k++) if (gtrace[k] === 4'b0010) cnt++;
            n_checks++; if (cnt != TOUT) $display("FAIL t5_idle_hold: got %0d cycles want %0d", cnt, TOUT); else n_pass++;
            n_checks++; if (gtrace[t0 + 17] !== 4'b0000) $display("FAIL t5_release: grant %b want 0000", gtrace[t0 + 17]); else n_pass++;
            n_checks++; if (gtrace[t0 + 18] !== 4'b1000) $display("FAIL t5_next_owner: grant %b want 1000", gtrace[t0 + 18]); else n_pass++;
        end else begin
            n_checks++;
            $display("FAIL t5_trace: log %0d entries, trace %0d cycles too short", out_log.size(), gtrace.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int nb;
        apply_reset();
        for (int k = 0; k < 10; k++) srcq[0].push_back(8'(8'h30 + k));
        nb = 0;
        while (out_log.size() < 4 && nb < 50) begin
            cycle();
            nb++;
        end
        n_checks++;
        if (out_log.size() < 4) $display("FAIL t6_prefill: got %0d bytes want 4", out_log.size()); else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++; if (ovalid !== 1'b0) $display("FAIL t6_ovalid: got %b want 0", ovalid); else n_pass++;
        n_checks++; if (iready !== '0) $display("FAIL t6_iready: got %b want 0000", iready); else n_pass++;
        n_checks++; if (grant !== '0) $display("FAIL t6_grant: got %b want 0000", grant); else n_pass++;
        for (int i = 0; i < NUM; i++) srcq[i].delete();
        srcq[0] = '{8'h0A};
        srcq[2] = '{8'h0A};
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc = 0; viol = 0; pops = 0;
        out_log.delete();
        gtrace.delete();
        build_model(NUM - 1);
        run(300);
        n_checks++;
        if (out_log.size() != exp_log.size())
            $display("FAIL t6_count: got %0d bytes want %0d", out_log.size(), exp_log.size());
        else n_pass++;
        for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
            n_checks++;
            if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                $display("FAIL t6_byte[%0d]: got %h/%b want %h/%b", k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int         nf, len;
        logic [7:0] b;
        for (int it = 0; it < 4; it++) begin
            apply_reset();
            omode = 2;
            for (int i = 0; i < NUM; i++) begin
                nf = $urandom_range(0, 3);
                for (int f = 0; f < nf; f++) begin
                    len = $urandom_range(1, 80);
                    for (int j = 0; j < len; j++) begin
                        b = 8'($urandom);
                        if (b == TERM) b = 8'h0B;
                        if (j == len - 1 && $urandom_range(0, 9) < 7) b = TERM;
                        srcq[i].push_back(b);
                    end
                end
            end
            build_model(NUM - 1);
            run(20000);
            n_checks++;
            if (out_log.size() != exp_log.size())
                $display("FAIL rnd%0d_count: got %0d bytes want %0d", it, out_log.size(), exp_log.size());
            else n_pass++;
            for (int k = 0; k < exp_log.size() && k < out_log.size(); k++) begin
                n_checks++;
                if (out_log[k].b !== exp_log[k].b || out_log[k].g !== exp_log[k].g)
                    $display("FAIL rnd%0d_byte[%0d]: got %h/%b want %h/%b", it, k, out_log[k].b, out_log[k].g, exp_log[k].b, exp_log[k].g);
                else n_pass++;
            end
            n_checks++; if (viol != 0) $display("FAIL rnd%0d_iready_rule: %0d bad cycles want 0", it, viol); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_max_burst();
        test_oready_toggle();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
